wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port of the microprocessor between two
//  requesters: A = ALU writeback, B = load-unit writeback.
//  Arbitration is round-robin with a one-stage registered output. The output
//  drives the register file and the OUTADDR/OUTDATA/OUTVALID trace bus.
//  Sequences end of run: after HALT_REQ, drains pending writes, then raises DONE.
// PARAMETERS
//  AW        5   register address width
//  DW        32  write data width
//  CW        16  width of write counter WR_COUNT
//  ZERO_DROP 1   1: writes to address 0 complete the handshake but produce no OUTVALID
// PORTS
//  CK        in   1   clock, all state updates on rising edge
//  RESET     in   1   reset, synchronous, active-low
//  A_VALID   in   1   ALU write request
//  A_ADDR    in   AW  ALU destination register
//  A_DATA    in   DW  ALU result
//  A_READY   out  1   ALU request accepted this cycle (combinational)
//  B_VALID   in   1   load-unit write request
//  B_ADDR    in   AW  load destination register
//  B_DATA    in   DW  load data
//  B_READY   out  1   load request accepted this cycle (combinational)
//  HALT_REQ  in   1   single-cycle halt pulse from decode
//  OUTADDR   out  AW  write address (registered)
//  OUTDATA   out  DW  write data (registered)
//  OUTVALID  out  1   write strobe, one cycle per committed write
//  WR_COUNT  out  CW  number of committed writes; wraps modulo 2^CW
//  DONE      out  1   sticky run-complete flag
// BEHAVIOUR
//  Reset (RESET=0 at edge):
//   - OUTADDR=0, OUTDATA=0, OUTVALID=0, WR_COUNT=0, DONE=0.
//   - state=RUN, last-grant pointer=B, so A wins the first tie.
//   - Reset mid-drain or in DONE state also returns to RUN and drops the output stage.
//  Handshake: a request transfers in a cycle where VALID=1 and READY=1.
//   - A requester holds VALID, ADDR and DATA stable until READY.
//   - The write port never stalls, so exactly one grant is possible per cycle in RUN/DRAIN.
//  Grant rules:
//   - Only A valid -> A. Only B valid -> B.
//   - Both valid -> the requester not granted last. The pointer updates only on a transfer.
//   - A_READY/B_READY are 0 in state DONE, and 0 while RESET=0.
//  Latency: transfer at edge N -> OUTADDR/OUTDATA/OUTVALID valid from edge N+1 for
//   exactly one cycle.
//   - OUTVALID=0 in any cycle with no prior transfer.
//   - OUTADDR/OUTDATA hold their last value when OUTVALID=0.
//  Address 0: with ZERO_DROP=1, a transfer with addr 0 still asserts READY but
//   OUTVALID stays 0 and WR_COUNT is unchanged. ZERO_DROP=0 treats it as a normal write.
//  WR_COUNT increments with each OUTVALID=1 cycle; 2^CW-1 wraps to 0.
//  FSM:
//   - RUN: HALT_REQ=1 -> DRAIN.
//   - DRAIN: grants continue; first cycle with A_VALID=0 and B_VALID=0 -> DONE.
//   - DONE: no grants; DONE=1 from the next edge on, sticky until reset.
//   - HALT_REQ in RUN while requests are pending is still serviced the same cycle;
//     the drain counts that grant.
//   - HALT_REQ in DRAIN or DONE is ignored.
//   - The final write's OUTVALID occurs at or before the first DONE=1 cycle, never after.
// TESTING
//  1 Reset: hold RESET=0 for 2 cycles with A_VALID=B_VALID=1 -> READYs 0,
//    OUTVALID 0, WR_COUNT 0, DONE 0.
//  2 Single: A_VALID=1, A_ADDR=5'h03, A_DATA=32'hDEADBEEF for 1 cycle -> next cycle
//    OUTVALID=1, OUTADDR=03, OUTDATA=DEADBEEF, WR_COUNT=1.
//  3 Contention: A and B both valid for 4 consecutive transfers (A addr 1/2, B addr 8/9)
//    -> grant order A,B,A,B; OUTADDR 01,08,02,09 on 4 consecutive cycles.
//  4 Zero drop: B writes addr 0, data 32'h12345678 -> B_READY=1, OUTVALID stays 0,
//    WR_COUNT unchanged.
//  5 Drain: HALT_REQ while A holds 2 more requests -> both written (OUTVALID x2),
//    then DONE=1 and stays 1; later A_VALID gets A_READY=0.
//  6 Reset during DRAIN: RESET=0 one cycle -> DONE=0, state RUN, WR_COUNT=0;
//    new write commits normally.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the register-file write port, with a
// registered output stage and a halt/drain/done sequence for the end of a run.
module wb_port_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int CW        = 16,
    parameter int ZERO_DROP = 1
) (
    input  logic          CK,
    input  logic          RESET,
    input  logic          A_VALID,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DATA,
    output logic          A_READY,
    input  logic          B_VALID,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_DATA,
    output logic          B_READY,
    input  logic          HALT_REQ,
    output logic [AW-1:0] OUTADDR,
    output logic [DW-1:0] OUTDATA,
    output logic          OUTVALID,
    output logic [CW-1:0] WR_COUNT,
    output logic          DONE
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nx;
    logic          last_b, active, ga, gb, commit;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    always_comb begin
        active   = RESET && state != S_DONE;
        ga       = active && A_VALID && (!B_VALID || last_b);
        gb       = active && B_VALID && (!A_VALID || !last_b);
        waddr    = ga ? A_ADDR : B_ADDR;
        wdata    = ga ? A_DATA : B_DATA;
        // Address-0 writes still handshake but never reach the port when dropping.
        commit   = (ga || gb) && !(ZERO_DROP != 0 && waddr == '0);
        state_nx = (state == S_RUN && HALT_REQ) ? S_DRAIN :
                   (state == S_DRAIN && !A_VALID && !B_VALID) ? S_DONE : state;
    end

    assign A_READY = ga;
    assign B_READY = gb;
    assign DONE    = state == S_DONE;

    always_ff @(posedge CK) begin
        if (!RESET) begin
            state    <= S_RUN;
            last_b   <= 1'b1;
            OUTVALID <= 1'b0;
            OUTADDR  <= '0;
            OUTDATA  <= '0;
            WR_COUNT <= '0;
        end else begin
            state    <= state_nx;
            OUTVALID <= commit;
            if (ga || gb) last_b <= gb;
            if (commit) begin
                OUTADDR  <= waddr;
                OUTDATA  <= wdata;
                WR_COUNT <= WR_COUNT + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed table of per-cycle vectors against the default
// configuration, plus a counter-wrap sequence on a narrow-counter instance.
module tb_wb_port_arbiter;
    logic        CK = 1'b0;
    logic        RESET = 1'b0, HALT_REQ = 1'b0;
    logic        A_VALID = 1'b0, B_VALID = 1'b0;
    logic [4:0]  A_ADDR = '0, B_ADDR = '0;
    logic [31:0] A_DATA = '0, B_DATA = '0;
    logic        A_READY, B_READY, OUTVALID, DONE;
    logic [4:0]  OUTADDR;
    logic [31:0] OUTDATA;
    logic [15:0] WR_COUNT;

    logic        r2 = 1'b0, av2 = 1'b0, ar2, br2, ov2, dn2;
    logic [4:0]  aa2 = '0, oa2;
    logic [31:0] ad2 = '0, od2;
    logic [2:0]  cnt2;

    int pass_cnt = 0, total = 0;

    always #5 CK = ~CK;

    wb_port_arbiter dut (
        .CK(CK), .RESET(RESET),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .HALT_REQ(HALT_REQ), .OUTADDR(OUTADDR), .OUTDATA(OUTDATA),
        .OUTVALID(OUTVALID), .WR_COUNT(WR_COUNT), .DONE(DONE)
    );

    wb_port_arbiter #(.CW(3), .ZERO_DROP(0)) dut2 (
        .CK(CK), .RESET(r2),
        .A_VALID(av2), .A_ADDR(aa2), .A_DATA(ad2), .A_READY(ar2),
        .B_VALID(1'b0), .B_ADDR(5'd0), .B_DATA(32'd0), .B_READY(br2),
        .HALT_REQ(1'b0), .OUTADDR(oa2), .OUTDATA(od2),
        .OUTVALID(ov2), .WR_COUNT(cnt2), .DONE(dn2)
    );

    typedef struct {
        logic        rst, halt, av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar, br, ov;
        logic [4:0]  oa;
        logic [31:0] od;
        logic [15:0] cnt;
        logic        dn;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    initial begin
        // rst halt av aa ad | bv ba bd | ar br | ov oa od cnt dn   (rst is RESET level)
        tbl[0]  = '{0,0,1,5'h01,32'h1,         1,5'h02,32'h2,         0,0, 0,5'h00,32'h0,         0,0};
        tbl[1]  = '{0,0,1,5'h01,32'h1,         1,5'h02,32'h2,         0,0, 0,5'h00,32'h0,         0,0};
        tbl[2]  = '{1,0,1,5'h03,32'hDEADBEEF,  0,5'h00,32'h0,         1,0, 1,5'h03,32'hDEADBEEF,  1,0};
        tbl[3]  = '{1,0,0,5'h00,32'h0,         0,5'h00,32'h0,         0,0, 0,5'h03,32'hDEADBEEF,  1,0};
        tbl[4]  = '{1,0,0,5'h00,32'h0,         1,5'h0A,32'h11111111,  0,1, 1,5'h0A,32'h11111111,  2,0};
        tbl[5]  = '{1,0,1,5'h01,32'hA1,        1,5'h08,32'hB8,        1,0, 1,5'h01,32'hA1,        3,0};
        tbl[6]  = '{1,0,1,5'h02,32'hA2,        1,5'h08,32'hB8,        0,1, 1,5'h08,32'hB8,        4,0};
        tbl[7]  = '{1,0,1,5'h02,32'hA2,        1,5'h09,32'hB9,        1,0, 1,5'h02,32'hA2,        5,0};
        tbl[8]  = '{1,0,1,5'h04,32'hA4,        1,5'h09,32'hB9,        0,1, 1,5'h09,32'hB9,        6,0};
        tbl[9]  = '{1,0,1,5'h04,32'hA4,        0,5'h00,32'h0,         1,0, 1,5'h04,32'hA4,        7,0};
        tbl[10] = '{1,0,0,5'h00,32'h0,         1,5'h00,32'h12345678,  0,1, 0,5'h04,32'hA4,        7,0};
        tbl[11] = '{1,0,0,5'h00,32'h0,         0,5'h00,32'h0,         0,0, 0,5'h04,32'hA4,        7,0};
        tbl[12] = '{1,1,1,5'h05,32'hA5,        0,5'h00,32'h0,         1,0, 1,5'h05,32'hA5,        8,0};
        tbl[13] = '{1,0,1,5'h06,32'hA6,        0,5'h00,32'h0,         1,0, 1,5'h06,32'hA6,        9,0};
        tbl[14] = '{1,0,0,5'h00,32'h0,         0,5'h00,32'h0,         0,0, 0,5'h06,32'hA6,        9,1};
        tbl[15] = '{1,0,1,5'h07,32'hA7,        0,5'h00,32'h0,         0,0, 0,5'h06,32'hA6,        9,1};
        tbl[16] = '{1,1,1,5'h07,32'hA7,        1,5'h0B,32'hBB,        0,0, 0,5'h06,32'hA6,        9,1};
        tbl[17] = '{0,0,0,5'h00,32'h0,         0,5'h00,32'h0,         0,0, 0,5'h00,32'h0,         0,0};
        tbl[18] = '{1,1,1,5'h02,32'hC2,        0,5'h00,32'h0,         1,0, 1,5'h02,32'hC2,        1,0};
        tbl[19] = '{0,0,1,5'h03,32'hC3,        0,5'h00,32'h0,         0,0, 0,5'h00,32'h0,         0,0};
        tbl[20] = '{1,0,1,5'h03,32'hC3,        0,5'h00,32'h0,         1,0, 1,5'h03,32'hC3,        1,0};
        tbl[21] = '{1,0,0,5'h00,32'h0,         0,5'h00,32'h0,         0,0, 0,5'h03,32'hC3,        1,0};

        for (int i = 0; i < 22; i++) begin
            @(negedge CK);
            RESET = tbl[i].rst; HALT_REQ = tbl[i].halt;
            A_VALID = tbl[i].av; A_ADDR = tbl[i].aa; A_DATA = tbl[i].ad;
            B_VALID = tbl[i].bv; B_ADDR = tbl[i].ba; B_DATA = tbl[i].bd;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(A_READY), 32'(tbl[i].ar));
            chk($sformatf("v%0d_b_ready", i), 32'(B_READY), 32'(tbl[i].br));
            @(posedge CK); #1;
            chk($sformatf("v%0d_outvalid", i), 32'(OUTVALID), 32'(tbl[i].ov));
            chk($sformatf("v%0d_outaddr", i), 32'(OUTADDR), 32'(tbl[i].oa));
            chk($sformatf("v%0d_outdata", i), OUTDATA, tbl[i].od);
            chk($sformatf("v%0d_wr_count", i), 32'(WR_COUNT), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_done", i), 32'(DONE), 32'(tbl[i].dn));
        end

        // Narrow counter wraps, and address 0 counts as a real write when not dropped.
        @(negedge CK); r2 = 1'b0;
        @(negedge CK); r2 = 1'b1; av2 = 1'b1; aa2 = 5'h00;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge CK);
            ad2 = 32'h100 + 32'(i);
            #1;
            chk($sformatf("w%0d_a_ready", i), 32'(ar2), 32'd1);
            @(posedge CK); #1;
            chk($sformatf("w%0d_outvalid", i), 32'(ov2), 32'd1);
            chk($sformatf("w%0d_outdata", i), od2, 32'h100 + 32'(i));
            chk($sformatf("w%0d_wr_count", i), 32'(cnt2), 32'((i + 1) % 8));
        end
        @(negedge CK); av2 = 1'b0;
        @(posedge CK); #1;
        chk("w_idle_outvalid", 32'(ov2), 32'd0);
        chk("w_idle_wr_count", 32'(cnt2), 32'd1);
        chk("w_idle_done", 32'(dn2), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
